// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants for the pipeline boundary registers and hazard logic
package pipe_pkg;
  localparam logic [31:0] EXC_PC_DEFAULT = 32'h0000_4180;
  localparam int TNEW_W_DEFAULT = 2;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
endpackage

// File: rtl/pipe_tnew_dec.sv
// pipe_tnew_dec: combinational saturating decrement of a Tnew countdown (tnew_i -> tnew_o, stops at 0)
module pipe_tnew_dec import pipe_pkg::*; #(
  parameter int TNEW_W = TNEW_W_DEFAULT
) (
  input  logic [TNEW_W-1:0] tnew_i,
  output logic [TNEW_W-1:0] tnew_o
);
  assign tnew_o = (tnew_i == '0) ? '0 : tnew_i - 1'b1;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic pipeline boundary register with reset > req > flush > stall > load priority
// Ports: clk, reset (sync, active-high), req (exception taken, only a clean 1 counts), flush, stall,
// upstream valid_i/pc_i/bd_i/exc_i/tnew_i/payload_i, registered valid_o/pc_o/bd_o/exc_o/tnew_o/payload_o.
// Define PIPE_STAGE_PERF_EN to add the saturating bubble counter output bubble_cnt_o.
module pipe_stage_reg import pipe_pkg::*; #(
  parameter int          PAYLOAD_W = 128,
  parameter int          TNEW_W    = TNEW_W_DEFAULT,
  parameter logic [31:0] EXC_PC    = EXC_PC_DEFAULT,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 flush,
  input  logic                 stall,
  input  logic                 valid_i,
  input  logic [31:0]          pc_i,
  input  logic                 bd_i,
  input  logic [4:0]           exc_i,
  input  logic [TNEW_W-1:0]    tnew_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  output logic                 valid_o,
  output logic [31:0]          pc_o,
  output logic                 bd_o,
  output logic [4:0]           exc_o,
  output logic [TNEW_W-1:0]    tnew_o,
  output logic [PAYLOAD_W-1:0] payload_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]          bubble_cnt_o
`endif
);
  logic take_req;
  logic bubble;
  logic [TNEW_W-1:0] tnew_next;
  // X/Z on req must not fire an exception
  assign take_req = (req === 1'b1);
  // an invalid load is a flush, but only when the stage is not held
  assign bubble = flush | (~stall & ~valid_i);
  pipe_tnew_dec #(.TNEW_W(TNEW_W)) u_dec (.tnew_i(tnew_i), .tnew_o(tnew_next));
  always_ff @(posedge clk) begin
    if (reset || take_req) begin
      valid_o   <= 1'b0;
      pc_o      <= reset ? RESET_PC : EXC_PC;
      bd_o      <= 1'b0;
      exc_o     <= '0;
      tnew_o    <= '0;
      payload_o <= '0;
    end else if (bubble) begin
      valid_o   <= 1'b0;
      pc_o      <= pc_i;
      bd_o      <= bd_i;
      exc_o     <= '0;
      tnew_o    <= '0;
      payload_o <= '0;
    end else if (!stall) begin
      valid_o   <= 1'b1;
      pc_o      <= pc_i;
      bd_o      <= bd_i;
      exc_o     <= exc_i;
      tnew_o    <= tnew_next;
      payload_o <= payload_i;
    end
  end
`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk) begin
    if (reset)
      bubble_cnt_o <= '0;
    else if ((take_req || bubble) && bubble_cnt_o != '1)
      bubble_cnt_o <= bubble_cnt_o + 32'd1;
  end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;
  import pipe_pkg::*;
  logic clk = 1'b0;
  logic reset, req, flush, stall, valid_i, bd_i;
  logic [31:0] pc_i;
  logic [4:0] exc_i;
  logic [1:0] tnew_i;
  logic [127:0] payload_i;
  logic valid_o, bd_o;
  logic [31:0] pc_o;
  logic [4:0] exc_o;
  logic [1:0] tnew_o;
  logic [127:0] payload_o;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] bubble_cnt_o;
`endif
  int total = 0;
  int bad = 0;
  localparam logic [127:0] P1 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [127:0] P2 = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .req(req), .flush(flush), .stall(stall),
    .valid_i(valid_i), .pc_i(pc_i), .bd_i(bd_i), .exc_i(exc_i), .tnew_i(tnew_i),
    .payload_i(payload_i), .valid_o(valid_o), .pc_o(pc_o), .bd_o(bd_o),
    .exc_o(exc_o), .tnew_o(tnew_o), .payload_o(payload_o)
`ifdef PIPE_STAGE_PERF_EN
    , .bubble_cnt_o(bubble_cnt_o)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_cnt(input string tag, input logic [31:0] exp);
`ifdef PIPE_STAGE_PERF_EN
    chk(tag, bubble_cnt_o, exp);
`else
    if (exp == 32'hffff_ffff) $display("unused %s", tag);
`endif
  endtask
  initial begin
    reset = 1; req = 1; flush = 1; stall = 1; valid_i = 1; bd_i = 1;
    pc_i = 32'hdead_beec; exc_i = EXC_RI; tnew_i = 2'd3; payload_i = P2;
    tick; tick;
    chk("rst_valid", valid_o, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_bd", bd_o, 0);
    chk("rst_exc", exc_o, 0);
    chk("rst_tnew", tnew_o, 0);
    chk("rst_payload", payload_o, 0);
    chk_cnt("rst_cnt", 0);
    reset = 0; req = 0; flush = 0; stall = 0; bd_i = 0;
    pc_i = 32'h3010; exc_i = EXC_INT; tnew_i = 2'd2; payload_i = P1;
    tick;
    chk("ld_valid", valid_o, 1);
    chk("ld_pc", pc_o, 32'h3010);
    chk("ld_tnew2", tnew_o, 1);
    chk("ld_payload", payload_o, P1);
    chk_cnt("ld_cnt", 0);
    pc_i = 32'h3014; tnew_i = 2'd0; exc_i = EXC_OV;
    tick;
    chk("ld_tnew0", tnew_o, 0);
    chk("ld_exc", exc_o, EXC_OV);
    pc_i = 32'h3018; tnew_i = 2'd3; exc_i = EXC_INT; bd_i = 1;
    tick;
    chk("ld_tnew3", tnew_o, 2);
    chk("ld_bd", bd_o, 1);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      pc_i = 32'h3100 + 32'(i * 4); tnew_i = 2'(i); valid_i = i[0]; payload_i = P2; bd_i = 0;
      tick;
      chk("stall_valid", valid_o, 1);
      chk("stall_pc", pc_o, 32'h3018);
      chk("stall_tnew", tnew_o, 2);
      chk("stall_bd", bd_o, 1);
      chk("stall_payload", payload_o, P1);
    end
    chk_cnt("stall_cnt", 0);
    req = 1; valid_i = 1; exc_i = EXC_ADEL;
    tick;
    chk("req_valid", valid_o, 0);
    chk("req_pc", pc_o, 32'h4180);
    chk("req_exc", exc_o, 0);
    chk("req_bd", bd_o, 0);
    chk("req_payload", payload_o, 0);
    chk_cnt("req_cnt", 1);
    req = 0; stall = 0; flush = 1; pc_i = 32'h3020; bd_i = 1; tnew_i = 2'd3; payload_i = P1;
    tick;
    chk("fl_valid", valid_o, 0);
    chk("fl_pc", pc_o, 32'h3020);
    chk("fl_bd", bd_o, 1);
    chk("fl_tnew", tnew_o, 0);
    chk("fl_exc", exc_o, 0);
    chk("fl_payload", payload_o, 0);
    chk_cnt("fl_cnt", 2);
    stall = 1; pc_i = 32'h3024; bd_i = 0;
    tick;
    chk("flst_pc", pc_o, 32'h3024);
    chk("flst_bd", bd_o, 0);
    chk_cnt("flst_cnt", 3);
    stall = 0; flush = 0; valid_i = 0; pc_i = 32'h3028; bd_i = 1; exc_i = EXC_ADES;
    tick;
    chk("inv_valid", valid_o, 0);
    chk("inv_pc", pc_o, 32'h3028);
    chk("inv_bd", bd_o, 1);
    chk("inv_exc", exc_o, 0);
    chk("inv_payload", payload_o, 0);
    chk_cnt("inv_cnt", 4);
    req = 1'bx; valid_i = 1; pc_i = 32'h3000; bd_i = 0; exc_i = EXC_INT; tnew_i = 2'd1; payload_i = P2;
    tick;
    chk("reqx_valid", valid_o, 1);
    chk("reqx_pc", pc_o, 32'h3000);
    chk("reqx_tnew", tnew_o, 0);
    chk("reqx_payload", payload_o, P2);
    chk_cnt("reqx_cnt", 4);
    req = 0; stall = 1; pc_i = 32'h3004;
    tick;
    chk("hold_pc", pc_o, 32'h3000);
    stall = 0; pc_i = 32'h3008; tnew_i = 2'd2;
    tick;
    chk("resume_pc", pc_o, 32'h3008);
    chk("resume_tnew", tnew_o, 1);
    stall = 1; reset = 1;
    tick;
    chk("rststall_valid", valid_o, 0);
    chk("rststall_pc", pc_o, 0);
    chk_cnt("rststall_cnt", 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline boundary register for the five-stage MIPS core, replacing the per-stage hand-written E/M/W registers with one generic block. It carries a valid bit, PC, branch-delay flag, exception code, hazard countdown (Tnew) and an opaque control/data payload across one stage boundary. It applies a fixed priority of reset, exception request, flush, stall and normal load. An optional bubble counter supports CPI measurement.

## Interface
Parameters:
- PAYLOAD_W, 128: width of opaque payload (control bits, ALU result, write data, dest regs, etc.)
- TNEW_W, 2: width of Tnew countdown field
- EXC_PC, 32'h0000_4180: PC loaded into pc_o when an exception request is taken
- RESET_PC, 32'h0000_0000: pc_o value after reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- req  in  1  exception/interrupt taken this cycle; X/Z treated as deasserted (case-equality against 1)
- flush  in  1  insert bubble (branch/hazard kill)
- stall  in  1  hold current contents
- valid_i  in  1  upstream instruction valid
- pc_i  in  32  upstream PC
- bd_i  in  1  upstream branch-delay-slot flag
- exc_i  in  5  upstream ExcCode (0 = none)
- tnew_i  in  TNEW_W  upstream cycles-until-result
- payload_i  in  PAYLOAD_W  upstream payload
- valid_o, pc_o, bd_o, exc_o, tnew_o, payload_o  out  matching widths  registered stage contents
- bubble_cnt_o  out  32  bubble counter (present only with PIPE_STAGE_PERF_EN)

## Operation
- Priority per edge: reset > req > flush > stall > load.
- reset: valid_o=0, pc_o=RESET_PC, bd_o=0, exc_o=0, tnew_o=0, payload_o=0, bubble_cnt_o=0.
- req: same clears as reset except pc_o=EXC_PC; bubble_cnt_o is not cleared.
- flush: bubble; valid_o=0, exc_o=0, tnew_o=0, payload_o=0; pc_o<=pc_i, bd_o<=bd_i (PC/BD kept for EPC on a later exception).
- stall: all outputs hold their values; Tnew does not age.
- load, valid_i=1: all fields copied; tnew_o <= (tnew_i==0) ? 0 : tnew_i-1 (saturating decrement, never wraps).
- load, valid_i=0: treated as flush (bubble with pc_i/bd_i carried).
- stall and flush together: flush wins. req with stall: req wins.
- Payload is never interpreted; zero payload must decode downstream as a no-op.

## Timing
- Latency is exactly 1 cycle from inputs to outputs. There is no combinational path from input to output.
- All outputs come straight from flops.
- A reset or req asserted mid-stall takes effect on the next edge regardless of stall.
- Following a deassertion of stall, the next edge loads normally; no cycle is lost.

## Configuration
- PIPE_STAGE_PERF_EN defined: a 32-bit bubble_cnt_o register is included.
  - It increments on every non-reset edge where the post-edge valid_o is 0, covering req, flush and invalid load.
  - It holds during stall.
  - It saturates at 32'hFFFF_FFFF.
- PIPE_STAGE_PERF_EN undefined: the port and counter are absent, with zero added flops.

## Structure
- Shared package pipe_pkg holds:
  - EXC_PC_DEFAULT (32'h0000_4180) and TNEW_W_DEFAULT (2).
  - ExcCode constants: EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12.
- Sub-module pipe_tnew_dec: combinational saturating decrement of width TNEW_W, reused by hazard unit tests.

## Test plan
- reset=1 for 2 cycles with all inputs nonzero -> all outputs 0, pc_o=0; bubble_cnt_o=0 when the counter is enabled.
- Load valid_i=1, pc_i=0x3010, tnew_i=2, exc_i=0, then tnew_i=0 -> tnew_o=1 next cycle, then 0 (no wrap to 3).
- req=1 together with stall=1 and valid_i=1 -> valid_o=0, pc_o=0x4180, exc_o=0, payload_o=0; bubble_cnt_o increments by 1.
- stall=1 for 3 cycles while inputs change -> outputs identical to the pre-stall values; bubble_cnt_o unchanged.
- flush=1 with pc_i=0x3020, bd_i=1 -> valid_o=0, pc_o=0x3020, bd_o=1, tnew_o=0, payload_o=0.
- req driven X during a load of pc_i=0x3000 -> normal load, pc_o=0x3000.
